// File: rtl/alu_pipe_seq.sv
`timescale 1ns/1ps
// Handshaked ALU with registered output; 1-cycle ops, WIDTH-cycle shift-add multiply.
// in_ready drops while multiplying or while a held result waits on out_ready.
module alu_pipe_seq #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);
    localparam int SH_W = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1101;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] res_c;
    logic             ill_c;
    logic [SH_W-1:0]  shamt;
    logic             accept;
    logic             is_mul;

    assign shamt   = b[SH_W-1:0];
    assign accept  = in_valid && in_ready;
    assign is_mul  = (alu_op == OP_MUL);
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        res_c = '0;
        ill_c = 1'b0;
        case (alu_op)
            OP_AND: res_c = a & b;
            OP_OR:  res_c = a | b;
            OP_ADD: res_c = a + b;
            OP_XOR: res_c = a ^ b;
            OP_SUB: res_c = a - b;
            OP_SLT: res_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL: res_c = a << shamt;
            OP_SRL: res_c = a >> shamt;
            OP_SRA: res_c = $unsigned($signed(a) >>> shamt);
            OP_NOR: res_c = ~(a | b);
            OP_MUL: res_c = '0;
            default: ill_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (accept) state_nxt = is_mul ? S_MUL : S_HOLD;
            end
            S_MUL: begin
                busy = 1'b1;
                if (cnt == LAST) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (accept)         state_nxt = is_mul ? S_MUL : S_HOLD;
                else if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output register only moves on an accept or on the last multiply step,
    // so it holds steady for the whole time out_valid waits on out_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else if (accept) begin
            if (is_mul) begin
                mcand  <= a;
                mplier <= b;
                acc    <= '0;
                cnt    <= '0;
            end else begin
                result  <= res_c;
                zero    <= (res_c == '0);
                illegal <= ill_c;
            end
        end else if (state == S_MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
                result  <= acc_nxt;
                zero    <= (acc_nxt == '0);
                illegal <= 1'b0;
            end
        end
    end
endmodule
